mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit that sits beside the combinational ALU in the EX stage.
- Takes the MULT/MULTU/DIV/DIVU work the single-cycle ALU cannot do, using a start/busy/done handshake.
- The pipeline control stalls on busy and reads results from the hi/lo registers.
- This is the sequenced counterpart to the ALU: same operand bus, opposite timing model.

Parameters:
- NUM_BITS, 32, operand width; hi and lo are NUM_BITS each.
- CNT_BITS, 6, iteration counter width; must satisfy 2^CNT_BITS > NUM_BITS.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on clk edge, accepted only when busy=0.
- mdu_op  input  2  operation: 2'b00 MULTU, 2'b01 MULT, 2'b10 DIVU, 2'b11 DIV.
- data1  input  NUM_BITS  multiplicand / dividend; captured at accept.
- data2  input  NUM_BITS  multiplier / divisor; captured at accept.
- busy  output  1  operation in flight; new start ignored.
- done  output  1  one-cycle pulse; hi/lo/div_by_zero updated this cycle.
- hi  output  NUM_BITS  product upper half / remainder.
- lo  output  NUM_BITS  product lower half / quotient.
- div_by_zero  output  1  registered with done; 1 when a DIV/DIVU had data2=0, held until the next done.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0. Reset overrides start and aborts any operation in flight; no done is issued for the aborted op.
- FSM states: IDLE -> RUN -> SIGN -> IDLE.
- IDLE:
  - On start=1, latch mdu_op.
  - Latch |data1| and |data2|; signed ops take two's-complement magnitude, unsigned ops pass through.
  - Latch sign flags; clear accumulator; counter=0; go to RUN.
- RUN:
  - One iteration per cycle for N=NUM_BITS cycles.
  - Multiply is shift-add on a 2*NUM_BITS accumulator, multiplier LSB first.
  - Divide is restoring, quotient MSB first, remainder NUM_BITS+1 bits wide for the trial subtract.
  - counter increments each cycle; at counter=N-1, go to SIGN.
- SIGN (one cycle), computes the final values and moves to IDLE:
  - Signed multiply: negate the 2*NUM_BITS product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- Result register update:
  - hi/lo/div_by_zero are written on the SIGN->IDLE edge, with done=1 for exactly the following cycle.
  - hi/lo hold their values until the next done.
- busy timing:
  - busy=1 from the cycle after the accept edge through the SIGN cycle.
  - busy=0 in the done cycle.
- Latency: accept at edge k; done is high after edge k+N+1 (33 edges for N=32).
- Back-to-back: start with done=1 is accepted (busy=0). No bubble beyond the done cycle.
- start while busy=1: ignored, not queued; captured operands are unchanged.
- Divide by zero:
  - Full latency is still taken.
  - Result is lo=all ones, hi=data1 as captured (raw, unsigned view), div_by_zero=1.
  - The sign fix-up is skipped.
- Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0, div_by_zero=0. This falls out of the magnitude arithmetic with NUM_BITS wrap.
- All arithmetic is modulo 2^NUM_BITS per half; no exceptions are raised.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - For MULT/MULTU, RUN exits to SIGN once the remaining shifted multiplier magnitude is zero.
  - RUN length is n = max(1, index of highest set bit of |data2| + 1); done is high after edge k+n+1.
  - DIV/DIVU keep the fixed N-iteration latency.
  - busy deasserts correspondingly early.
- Undefined: every op takes exactly N RUN cycles. Results are bit-identical either way; only latency differs.

Test Plan:
- MULT data1=0xFFFFFFFD (-3), data2=7, start at edge 0 -> done high only after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 after edges 1..32 then 0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then DIV 0xFFFFFFF9 (-7) / 2 issued in the done cycle -> accepted; lo=0xFFFFFFFD, hi=0xFFFFFFFF, done 33 edges later.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done. Follow with DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- MULTU 5*3 started, start pulsed with different operands at edge 10 -> ignored; result lo=15, hi=0. Repeat, with rst at edge 10 -> busy=0, hi=lo=0 after edge 10, no done pulse thereafter; a new start at edge 11 is accepted.
- With MDU_EARLY_OUT_EN: MULTU 0x1234*3 -> n=2, done high after edge 3, lo=0x369C. MULTU x*0 -> done after edge 2, result 0. Without the macro, both finish after edge 33.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with start/busy/done handshake.
// Optional: define MDU_EARLY_OUT_EN to end multiplies once the remaining multiplier is zero.
module mult_div_unit #(
  parameter int NUM_BITS = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mdu_op,
  input  logic [NUM_BITS-1:0] data1,
  input  logic [NUM_BITS-1:0] data2,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] hi,
  output logic [NUM_BITS-1:0] lo,
  output logic                div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SIGN} state_t;

  state_t                  state, state_nxt;
  logic                    op_div, neg_a, neg_b;
  logic [NUM_BITS-1:0]     b_reg, quo, rem;
  logic [2*NUM_BITS-1:0]   mcand, acc;
  logic [CNT_BITS-1:0]     cnt;
  logic                    run_last;
  logic [NUM_BITS-1:0]     mag1, mag2;
  logic [NUM_BITS:0]       shifted, diff;
  logic [2*NUM_BITS-1:0]   prod_fix;
  logic [NUM_BITS-1:0]     quo_fix, rem_fix, a_raw;

  // Operand magnitudes: signed ops (mdu_op[0]) take the two's-complement absolute value.
  assign mag1 = (mdu_op[0] && data1[NUM_BITS-1]) ? -data1 : data1;
  assign mag2 = (mdu_op[0] && data2[NUM_BITS-1]) ? -data2 : data2;

  // Restoring-divide trial subtract on the widened partial remainder.
  assign shifted = {rem, quo[NUM_BITS-1]};
  assign diff    = shifted - {1'b0, b_reg};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_RUN;
      S_RUN:   if (run_last) state_nxt = S_SIGN;
      S_SIGN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_comb begin
    run_last = (cnt == CNT_BITS'(NUM_BITS - 1));
`ifdef MDU_EARLY_OUT_EN
    if (!op_div && ((b_reg >> 1) == '0)) run_last = 1'b1;
`endif
  end

  // NOTE: the datapath registers are reloaded on every accept, so they carry no reset;
  // only control state and the architecturally visible results are reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start) begin
        // NOTE: sequential state always uses non-blocking assignments.
        op_div <= mdu_op[1];
        neg_a  <= mdu_op[0] & data1[NUM_BITS-1];
        neg_b  <= mdu_op[0] & data2[NUM_BITS-1];
        mcand  <= {{NUM_BITS{1'b0}}, mag1};
        b_reg  <= mag2;
        quo    <= mag1;
        rem    <= '0;
        acc    <= '0;
        cnt    <= '0;
      end
      S_RUN: begin
        cnt <= cnt + CNT_BITS'(1);
        if (op_div) begin
          if (!diff[NUM_BITS]) begin
            rem <= diff[NUM_BITS-1:0];
            quo <= {quo[NUM_BITS-2:0], 1'b1};
          end else begin
            rem <= shifted[NUM_BITS-1:0];
            quo <= {quo[NUM_BITS-2:0], 1'b0};
          end
        end else begin
          if (b_reg[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          b_reg <= b_reg >> 1;
        end
      end
      default: ;
    endcase
  end

  // Sign fix-up; the remainder follows the dividend's sign.
  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
    rem_fix  = neg_a ? -rem : rem;
    a_raw    = neg_a ? -mcand[NUM_BITS-1:0] : mcand[NUM_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == S_SIGN);
      if (state == S_SIGN) begin
        if (!op_div) begin
          {hi, lo}    <= prod_fix;
          div_by_zero <= 1'b0;
        end else if (b_reg == '0) begin
          lo          <= '1;
          hi          <= a_raw;
          div_by_zero <= 1'b1;
        end else begin
          lo          <= quo_fix;
          hi          <= rem_fix;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  mdu_op;
  logic [31:0] data1, data2;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.NUM_BITS(32), .CNT_BITS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .mdu_op(mdu_op),
    .data1(data1), .data2(data2), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic, low halves taken modulo 2^32.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
      2'b01: begin p = 64'(sa * sb); {eh, el} = p; end
      default: begin
        if (b == 0) begin
          el = 32'hFFFF_FFFF; eh = a; edz = 1'b1;
        end else if (op == 2'b10) begin
          el = a / b; eh = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    int n;
    logic [31:0] m;
    n = 32;
    m = (op[0] && b[31]) ? -b : b;
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    end
`else
    if (m == 32'hDEAD_BEEF) n = 32;
`endif
    return n + 1;
  endfunction

  // Issues one op at the next falling edge (so back-to-back when called in a done cycle),
  // then waits (bounded) for done and checks latency, busy and results.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    logic [31:0] eh, el;
    logic        edz;
    int          lat, edges;
    bit          busy_ok;
    model(op, a, b, eh, el, edz);
    lat = exp_lat(op, b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; data1 = a; data2 = b;
    @(posedge clk); #1;
    start = 1'b0; data1 = $urandom; data2 = $urandom;
    edges = 0; busy_ok = 1'b1;
    while (!done && edges < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (poke && edges == 5) begin
        start = 1'b1; mdu_op = 2'($urandom); data1 = $urandom; data2 = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    check("latency", 64'(edges), 64'(lat));
    check("busy_run", 64'(busy_ok), 64'd1);
    check("busy_done", 64'(busy), 64'd0);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; mdu_op = '0; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dz", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg7by2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(2'b10, 32'd100, 32'd0, 1'b0);
    check("divu_by0", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    do_op(2'b10, 32'd100, 32'd7, 1'b0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0);
    do_op(2'b00, 32'd5, 32'd3, 1'b1);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("hold_lo", 64'(lo), 64'd15);

    // Abort an op in flight with reset, then start a fresh one.
    @(negedge clk);
    start = 1'b1; mdu_op = 2'b00; data1 = 32'd9; data2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    do_op(2'b00, 32'd5, 32'd3, 1'b0);

    do_op(2'b00, 32'h1234, 32'd3, 1'b0);
    check("mul_1234x3", 64'(lo), 64'h369C);
    do_op(2'b00, $urandom, 32'd0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(0, 15);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(op, a, b, (i % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
